ifu_prefetch: RTL and testbench



---
 rtl/ifu_prefetch_pkg.sv | 22 ++
 rtl/ifu_prefetch_if.sv | 36 +++
 rtl/ifu_prefetch_buf.sv | 95 +++++++++
 rtl/ifu_prefetch.sv | 85 ++++++++
 tb/tb_ifu_prefetch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared widths, depth and helpers for the instruction prefetch unit
package ifu_prefetch_pkg;

    // Fetch address and instruction widths used across the front end.
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    // Default prefetch buffer depth, also the cap on outstanding requests.
    localparam int FETCH_DEPTH = 4;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of the discard counter: stale responses can exceed one buffer's worth
    // when redirects land while older discards are still outstanding.
    function automatic int drop_width(input int depth);
        return $clog2(2 * depth) + 1;
    endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - redirect, memory request/response and IF/ID output bundle
//
// Signals:
//   redirect, redirect_pc      flush request and new fetch address
//   req_valid/req_ready/req_addr  word fetch request to instruction memory
//   rsp_valid/rsp_data         in-order instruction response, no backpressure
//   out_valid/out_ready/out_inst/out_pc  instruction stream to IF/ID
// Modports:
//   master  the prefetch unit
//   slave   memory, pipeline and redirect source
interface ifu_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        input  redirect, redirect_pc, req_ready, rsp_valid, rsp_data, out_ready,
        output req_valid, req_addr, out_valid, out_inst, out_pc
    );

    modport slave (
        output redirect, redirect_pc, req_ready, rsp_valid, rsp_data, out_ready,
        input  req_valid, req_addr, out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/ifu_prefetch_buf.sv
// rtl/ifu_prefetch_buf.sv - in-order {pc, inst, filled} buffer with alloc/fill/read pointers
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every entry and rewind all pointers
//   alloc, alloc_pc   reserve the next entry for an accepted request
//   fill, fill_data   write the oldest unfilled entry with its instruction
//   pop               consumer takes the head entry (ignored unless it is filled)
//   head_valid/head_pc/head_inst  head entry state
//   alloc_cnt         entries allocated and not yet freed (0..DEPTH)
//   unfilled_cnt      entries allocated whose response has not yet arrived
import ifu_prefetch_pkg::*;

module ifu_prefetch_buf #(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W,
    parameter int DEPTH  = FETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_inst,
    output logic [CNT_W-1:0]  alloc_cnt,
    output logic [CNT_W-1:0]  unfilled_cnt
);

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  alloc_cnt_q;
    logic [CNT_W-1:0]  unfilled_q;
    logic              do_pop;

    // Only a filled head can leave; the consumer's ready alone frees nothing.
    assign do_pop = pop && filled_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            filled_q    <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            alloc_cnt_q <= '0;
            unfilled_q  <= '0;
        end else if (flush) begin
            filled_q    <= '0;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            alloc_cnt_q <= '0;
            unfilled_q  <= '0;
        end else begin
            if (alloc) begin
                pc_q[wr_ptr] <= alloc_pc;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            // Fill and pop always target different entries: fill lands on an
            // unfilled entry, pop requires a filled one.
            if (fill) begin
                inst_q[fill_ptr]   <= fill_data;
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                filled_q[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            alloc_cnt_q <= alloc_cnt_q + CNT_W'(alloc) - CNT_W'(do_pop);
            unfilled_q  <= unfilled_q + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    assign head_valid   = filled_q[rd_ptr];
    assign head_pc      = pc_q[rd_ptr];
    assign head_inst    = inst_q[rd_ptr];
    assign alloc_cnt    = alloc_cnt_q;
    assign unfilled_cnt = unfilled_q;

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit between instruction memory and IF/ID
//
// Owns the fetch PC, issues in-order word requests, buffers up to DEPTH
// {pc, inst} pairs and presents them in order. A redirect flushes the buffer,
// counts in-flight responses to discard, and restarts at the new word address.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   ifu_prefetch_if.master: redirect/redirect_pc in, req_* to memory,
//         rsp_* from memory, out_* to IF/ID
import ifu_prefetch_pkg::*;

module ifu_prefetch #(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                DATA_W   = INST_W,
    parameter int                DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    ifu_prefetch_if.master bus
);

    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int DROP_W = drop_width(DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0]  alloc_cnt;
    logic [CNT_W-1:0]  unfilled_cnt;
    logic              req_valid;
    logic              issue;
    logic              rsp_keep;

    // No request in the redirect cycle: its address would be the stale pc.
    assign req_valid = !rst && !bus.redirect && (alloc_cnt < CNT_W'(DEPTH));
    assign issue     = req_valid && bus.req_ready;

    // A response belongs to a live entry only once every stale one is gone.
    assign rsp_keep  = bus.rsp_valid && (drop_cnt_q == '0) && !bus.redirect;

    assign bus.req_valid = req_valid;
    assign bus.req_addr  = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else if (bus.redirect) begin
            pc_q <= bus.redirect_pc & ~ADDR_W'(3);
            // Everything still owed by memory becomes stale; a response arriving
            // this very cycle is consumed here, so it comes off the total.
            drop_cnt_q <= drop_cnt_q + DROP_W'(unfilled_cnt) - DROP_W'(bus.rsp_valid);
        end else begin
            if (issue) begin
                pc_q <= pc_q + ADDR_W'(4);
            end
            if (bus.rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_q <= drop_cnt_q - DROP_W'(1);
            end
        end
    end

    ifu_prefetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.redirect),
        .alloc        (issue),
        .alloc_pc     (pc_q),
        .fill         (rsp_keep),
        .fill_data    (bus.rsp_data),
        .pop          (bus.out_ready),
        .head_valid   (bus.out_valid),
        .head_pc      (bus.out_pc),
        .head_inst    (bus.out_inst),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - self-checking bench for ifu_prefetch
module tb_ifu_prefetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ifu_prefetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    bit          chk_inv = 1'b0;
    bit          post_redirect = 1'b0;
    int          last_due = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          out_mark = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] first_out_pc = 32'h0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        bit          present;
        int          l;
        int          due;
        logic [31:0] dcnt;
        logic [31:0] ucnt;
        present = (q_addr.size() > 0) && (q_due[0] <= cyc);
        bus.rsp_valid = present;
        bus.rsp_data  = present ? inst_of(q_addr[0]) : 32'h0;
        #1;
        if (post_redirect) begin
            check("out_valid_after_redirect", bus.out_valid, 1'b0);
            if (!bus.redirect) check("req_valid_after_redirect", bus.req_valid, 1'b1);
        end
        if (chk_inv) begin
            dcnt = 32'(dut.drop_cnt_q);
            ucnt = 32'(dut.u_buf.unfilled_q);
            check("drop_le_inflight", (dcnt <= 32'(q_addr.size())), 1'b1);
            if (present && dcnt == 0 && !bus.redirect)
                check("rsp_has_entry", (ucnt != 0), 1'b1);
        end
        if (bus.req_valid && bus.req_ready) begin
            l   = rand_lat ? int'($urandom_range(1, 5)) : lat;
            due = cyc + l;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_addr.push_back(bus.req_addr);
            q_due.push_back(due);
            n_acc++;
        end
        if (present) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (!bus.redirect && bus.out_valid && bus.out_ready) begin
            check("out_pc", bus.out_pc, exp_pc);
            check("out_inst", bus.out_inst, inst_of(exp_pc));
            if (n_out == out_mark) first_out_pc = bus.out_pc;
            exp_pc = exp_pc + 32'd4;
            n_out++;
        end
        if (bus.redirect) begin
            exp_pc        = bus.redirect_pc & 32'hFFFF_FFFC;
            out_mark      = n_out;
            post_redirect = 1'b1;
        end else begin
            post_redirect = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.req_ready   = 1'b1;
        bus.rsp_valid   = 1'b0;
        bus.rsp_data    = 32'h0;
        bus.out_ready   = 1'b1;
        q_addr.delete();
        q_due.delete();
        last_due      = 0;
        exp_pc        = 32'h0;
        out_mark      = n_out;
        post_redirect = 1'b0;
        repeat (2) @(posedge clk);
        cyc += 2;
        @(negedge clk);
        #1;
        check("rst_req_valid", bus.req_valid, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_inst", bus.out_inst, 32'h0);
        check("rst_drop_cnt", 32'(dut.drop_cnt_q), 32'h0);
        rst = 1'b0;
        #1;
        check("rst_req_addr", bus.req_addr, 32'h0);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        tick();
        bus.redirect    = 1'b0;
    endtask

    int o0;
    int a0;

    initial begin
        @(negedge clk);

        // Streaming: next-cycle memory, consumer always ready.
        do_reset();
        lat = 1;
        o0 = n_out;
        repeat (12) tick();
        check("stream_count", n_out - o0, 10);

        // Held pipeline fills the buffer, then drains in order.
        do_reset();
        bus.out_ready = 1'b0;
        a0 = n_acc;
        repeat (3) tick();
        check("hold_pc_early", bus.out_pc, 32'h0);
        repeat (7) tick();
        #1;
        check("hold_accepts", n_acc - a0, 4);
        check("hold_req_valid", bus.req_valid, 1'b0);
        check("hold_out_valid", bus.out_valid, 1'b1);
        check("hold_out_pc", bus.out_pc, 32'h0);
        check("hold_out_inst", bus.out_inst, inst_of(32'h0));
        bus.out_ready = 1'b1;
        o0 = n_out;
        repeat (4) tick();
        check("drain_count", n_out - o0, 4);

        // Latency 4: redirect with three requests in flight and no response.
        do_reset();
        lat = 4;
        repeat (3) tick();
        do_redirect(32'h100);
        check("drop_three", 32'(dut.drop_cnt_q), 32'd3);
        repeat (14) tick();
        check("redir_first_pc", first_out_pc, 32'h100);
        check("redir_drop_done", 32'(dut.drop_cnt_q), 32'd0);

        // Latency 3: redirect lands together with the first response.
        do_reset();
        lat = 3;
        repeat (3) tick();
        do_redirect(32'h40);
        check("drop_same_cycle", 32'(dut.drop_cnt_q), 32'd2);
        check("inflight_same_cycle", q_addr.size(), 2);
        repeat (10) tick();
        check("same_cycle_first_pc", first_out_pc, 32'h40);

        // Redirect to an unaligned target while the buffer is full.
        do_reset();
        lat = 1;
        bus.out_ready = 1'b0;
        repeat (8) tick();
        do_redirect(32'h203);
        #1;
        check("unaligned_req_addr", bus.req_addr, 32'h200);
        check("full_redirect_drop", 32'(dut.drop_cnt_q), 32'd0);
        bus.out_ready = 1'b1;
        o0 = n_out;
        repeat (6) tick();
        check("unaligned_first_pc", first_out_pc, 32'h200);
        check("unaligned_count", n_out - o0, 4);

        // Address wrap at the top of the space, no stall.
        do_redirect(32'hFFFF_FFF8);
        o0 = n_out;
        repeat (8) tick();
        check("wrap_first_pc", first_out_pc, 32'hFFFF_FFF8);
        check("wrap_count", n_out - o0, 6);

        // Random ready, latency and redirects against the PC model.
        do_reset();
        rand_lat = 1'b1;
        chk_inv  = 1'b1;
        o0 = n_out;
        for (int i = 0; i < 10000; i++) begin
            bus.req_ready   = ($urandom_range(0, 3) != 0);
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 63) == 0);
            bus.redirect_pc = $urandom;
            tick();
        end
        bus.redirect = 1'b0;
        check("rand_outputs", (n_out - o0) > 500, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
